pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//   Parametrised pipeline stage register: next generation of the ID/EX-style latch.
//   Carries one payload word between any two CPU stages (IF/ID, ID/EX, EX/MEM, ...) with a
//   valid/ready handshake, an optional 2-entry skid buffer that cuts the combinational
//   ready path, a synchronous flush for branch mispredict, global rdy pause, and a
//   downstream-stall counter. Stages pack their fields (pc, rs1, rs2, imm, rd, rd_en)
//   into up_data.
// PARAMETERS
//   DATA_W   32*4+5+1  payload width in bits (>=1)
//   SKID_EN  1         1: two entries, registered up_ready; 0: one entry, combinational up_ready
//   CNT_W    16        width of stall_cnt (>=1)
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous reset, active-low
//   rdy        in   1        global enable; 0 = freeze every register, no transfers
//   flush      in   1        synchronous kill of all held and incoming entries
//   up_valid   in   1        upstream offers up_data
//   up_ready   out  1        this stage accepts this cycle
//   up_data    in   DATA_W   upstream payload
//   dn_valid   out  1        dn_data holds a valid entry
//   dn_ready   in   1        downstream accepts this cycle
//   dn_data    out  DATA_W   payload of the oldest entry
//   occupancy  out  2        number of valid entries (0..2; max 1 when SKID_EN=0)
//   stall_cnt  out  CNT_W    saturating count of downstream back-pressure cycles
// BEHAVIOUR
//   - Reset (rst=0, async): dn_valid=0, occupancy=0, stall_cnt=0, dn_data=0, skid reg=0.
//     SKID_EN=1: up_ready=0 while rst=0, then 1 from the first cycle after release.
//   - Handshakes: up_fire = up_valid&up_ready&rdy; dn_fire = dn_valid&dn_ready&rdy.
//     No handshake counts while rdy=0.
//   - dn_valid/dn_data are registered and stay stable while dn_valid=1 and !dn_fire.
//   - rdy=0: no register changes. flush and stall counting are also ignored.
//   - States (SKID_EN=1): EMPTY(0), ONE(1, main valid), TWO(2, main+skid valid).
//     EMPTY: up_fire -> ONE, main<=up_data.
//     ONE: up_fire&dn_fire -> ONE, main<=up_data.
//          up_fire&!dn_fire -> TWO, skid<=up_data.
//          !up_fire&dn_fire -> EMPTY.
//     TWO: up_ready=0. dn_fire -> ONE, main<=skid. Otherwise hold.
//     up_ready = (state!=TWO), driven from a register with no combinational path
//     from dn_ready.
//   - SKID_EN=0: states EMPTY/ONE only; up_ready = !dn_valid | dn_ready (combinational).
//     ONE with up_fire&dn_fire reloads main.
//   - Latency: up_fire in cycle N -> dn_valid=1 in cycle N+1 (when empty or draining).
//   - Ordering: strict FIFO. No entry is lost or duplicated outside flush.
//   - flush=1 & rdy=1: next state EMPTY, occupancy=0, dn_valid=0. The up_data offered
//     that cycle is discarded. up_ready may still be 1 that cycle (upstream treats it as
//     accepted-and-killed). Data registers retain their contents; dn_data is don't-care
//     while dn_valid=0. stall_cnt is not cleared.
//     flush has priority over every transition in the same cycle.
//   - stall_cnt: +1 on each rdy=1 cycle with dn_valid=1 & dn_ready=0 & flush=0.
//     Saturates at 2^CNT_W-1. Only rst clears it.
//   - occupancy equals the state encoding and is never 3.
// TESTING
//   1 Reset mid-traffic: TWO state, drop rst for 1 ns -> dn_valid=0, occupancy=0,
//     stall_cnt=0 immediately (async). up_ready=1 on first cycle after release.
//   2 Streaming: up_valid=1, dn_ready=1, data 0..9 on consecutive cycles -> dn_data 0..9
//     one cycle later, one per cycle, occupancy=1 throughout.
//   3 Skid fill: ONE holding 0xA, push 0xB with dn_ready=0 -> occupancy=2, up_ready=0.
//     Then dn_ready=1 -> 0xA, then 0xB, in order, with no bubble.
//   4 Flush priority: TWO state, flush=1 with up_valid=1 (0xC) and dn_ready=1 ->
//     next cycle dn_valid=0, occupancy=0, 0xC never appears at dn.
//   5 rdy pause: rdy=0 for 3 cycles with up_valid=1, dn_ready=1, flush=1 -> no state,
//     data or stall_cnt change. Normal operation resumes when rdy=1.
//   6 Counter saturation, CNT_W=3: hold dn_valid=1, dn_ready=0 for 10 cycles ->
//     stall_cnt reads 1..7, then stays 7. A following flush leaves it at 7.
//   7 SKID_EN=0: random valid/ready vs. scoreboard -> occupancy<=1, FIFO order kept,
//     up_ready == !dn_valid|dn_ready every cycle.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Pipeline stage latch with a valid/ready handshake and an optional 2-entry skid buffer.
// Also provides a flush, a global rdy pause and a saturating downstream-stall counter.
module pipe_stage_buf #(
    parameter int unsigned DATA_W  = 32*4+5+1,
    parameter int unsigned SKID_EN = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_up_ready;
    logic [DATA_W-1:0]   r_main;
    logic [DATA_W-1:0]   r_skid;
    logic [CNT_W-1:0]    r_stall;

    logic                w_up_fire;
    logic                w_dn_fire;
    logic                w_load_main;
    logic                w_load_skid;
    logic                w_main_from_skid;
    logic                w_stall_inc;

    // Skid mode presents a registered ready; otherwise ready looks through to dn_ready.
    assign up_ready  = (SKID_EN != 0) ? r_up_ready : (~dn_valid | dn_ready);
    assign dn_valid  = (r_state != ST_EMPTY);
    assign dn_data   = r_main;
    assign occupancy = r_state;
    assign stall_cnt = r_stall;

    assign w_up_fire   = up_valid & up_ready & rdy;
    assign w_dn_fire   = dn_valid & dn_ready & rdy;
    assign w_stall_inc = rdy & dn_valid & ~dn_ready & ~flush & (r_stall != {CNT_W{1'b1}});

    // Next-state and data-load decode; flush overrides every transition.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_up_fire) begin
                    w_state_nxt = ST_ONE;
                    w_load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_up_fire && w_dn_fire) begin
                    w_load_main = 1'b1;
                end else if (w_up_fire) begin
                    w_state_nxt = (SKID_EN != 0) ? ST_TWO : ST_ONE;
                    w_load_skid = 1'b1;
                end else if (w_dn_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_dn_fire) begin
                    w_state_nxt      = ST_ONE;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        if (flush && rdy) begin
            w_state_nxt      = ST_EMPTY;
            w_load_main      = 1'b0;
            w_load_skid      = 1'b0;
            w_main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_EMPTY;
            r_up_ready <= 1'b0;
            r_main     <= '0;
            r_skid     <= '0;
            r_stall    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_up_ready <= (w_state_nxt != ST_TWO);
            if (w_load_main) begin
                r_main <= up_data;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= up_data;
            end
            if (w_stall_inc) begin
                r_stall <= r_stall + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: skid (CNT_W=16 and CNT_W=3) and no-skid variants
// share one stimulus bus; each scenario checks the instance it targets.
`timescale 1ns/100ps
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        up_valid;
    logic [31:0] up_data;
    logic        dn_ready;

    logic        dut_up_ready, dut_dn_valid;
    logic [31:0] dut_dn_data;
    logic [1:0]  dut_occ;
    logic [15:0] dut_stall;

    logic        sat_up_ready, sat_dn_valid;
    logic [31:0] sat_dn_data;
    logic [1:0]  sat_occ;
    logic [2:0]  sat_stall;

    logic        ns_up_ready, ns_dn_valid;
    logic [31:0] ns_dn_data;
    logic [1:0]  ns_occ;
    logic [15:0] ns_stall;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] sb[$];
    int          exp_stall = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(32), .SKID_EN(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .up_valid(up_valid), .up_ready(dut_up_ready), .up_data(up_data),
        .dn_valid(dut_dn_valid), .dn_ready(dn_ready), .dn_data(dut_dn_data),
        .occupancy(dut_occ), .stall_cnt(dut_stall)
    );

    pipe_stage_buf #(.DATA_W(32), .SKID_EN(1), .CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .up_valid(up_valid), .up_ready(sat_up_ready), .up_data(up_data),
        .dn_valid(sat_dn_valid), .dn_ready(dn_ready), .dn_data(sat_dn_data),
        .occupancy(sat_occ), .stall_cnt(sat_stall)
    );

    pipe_stage_buf #(.DATA_W(32), .SKID_EN(0), .CNT_W(16)) u_ns (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .up_valid(up_valid), .up_ready(ns_up_ready), .up_data(up_data),
        .dn_valid(ns_dn_valid), .dn_ready(dn_ready), .dn_data(ns_dn_data),
        .occupancy(ns_occ), .stall_cnt(ns_stall)
    );

    // Drive one cycle; called at posedge+1, returns at the next posedge+1.
    task automatic cyc(input logic v, input logic [31:0] d, input logic dr, input logic fl,
                       input logic rd, input bit ns, output bit upf, output bit dnf,
                       output logic [31:0] dd, output logic ur, output logic dv);
        up_valid = v; up_data = d; dn_ready = dr; flush = fl; rdy = rd;
        #1;
        ur  = ns ? ns_up_ready : dut_up_ready;
        dv  = ns ? ns_dn_valid : dut_dn_valid;
        dd  = ns ? ns_dn_data  : dut_dn_data;
        upf = v && ur && rd && !fl;
        dnf = dv && dr && rd && !fl;
        if (!ns && rd && sb.size() > 0 && !dr && !fl) exp_stall++;
        if (rd && fl) sb.delete();
        else if (upf) sb.push_back(d);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; up_valid = 1'b0; dn_ready = 1'b0; flush = 1'b0; rdy = 1'b1;
        #2; rst = 1'b1;
        @(posedge clk); #1;
        sb.delete(); exp_stall = 0;
    endtask

    task automatic test_reset();
        bit upf, dnf; logic [31:0] dd; logic ur, dv;
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b0; up_data = '0;
        #2;
        checks++; if (dut_dn_valid !== 1'b0) begin failures++; $display("FAIL rst_dn_valid got=%b exp=0", dut_dn_valid); end
        checks++; if (dut_occ !== 2'd0) begin failures++; $display("FAIL rst_occ got=%0d exp=0", dut_occ); end
        checks++; if (dut_stall !== 16'd0) begin failures++; $display("FAIL rst_stall got=%0d exp=0", dut_stall); end
        checks++; if (dut_dn_data !== 32'd0) begin failures++; $display("FAIL rst_dn_data got=%h exp=0", dut_dn_data); end
        checks++; if (dut_up_ready !== 1'b0) begin failures++; $display("FAIL rst_up_ready got=%b exp=0", dut_up_ready); end
        #6; rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (dut_up_ready !== 1'b1) begin failures++; $display("FAIL rel_up_ready got=%b exp=1", dut_up_ready); end
        // Reach TWO, then pulse reset asynchronously mid-cycle
        cyc(1'b1, 32'h1, 1'b0, 1'b0, 1'b1, 1'b0, upf, dnf, dd, ur, dv);
        cyc(1'b1, 32'h2, 1'b0, 1'b0, 1'b1, 1'b0, upf, dnf, dd, ur, dv);
        checks++; if (dut_occ !== 2'd2) begin failures++; $display("FAIL pre_rst_occ got=%0d exp=2", dut_occ); end
        checks++; if (dut_stall !== 16'(exp_stall)) begin failures++; $display("FAIL pre_rst_stall got=%0d exp=%0d", dut_stall, exp_stall); end
        #1; rst = 1'b0; #0.5;
        checks++; if (dut_dn_valid !== 1'b0 || dut_occ !== 2'd0 || dut_stall !== 16'd0) begin
            failures++; $display("FAIL async_rst got v=%b occ=%0d stall=%0d exp 0/0/0", dut_dn_valid, dut_occ, dut_stall);
        end
        #0.5; rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (dut_up_ready !== 1'b1) begin failures++; $display("FAIL rel2_up_ready got=%b exp=1", dut_up_ready); end
        sb.delete(); exp_stall = 0;
    endtask

    task automatic test_stream();
        bit upf, dnf; logic [31:0] dd, ex; logic ur, dv;
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 32'(k), 1'b1, 1'b0, 1'b1, 1'b0, upf, dnf, dd, ur, dv);
            if (k > 0) begin
                checks++;
                if (!dnf || sb.size() == 0) begin failures++; $display("FAIL stream_bubble k=%0d dn_valid=%b exp=1", k, dv); end
                else begin ex = sb.pop_front(); if (dd !== ex) begin failures++; $display("FAIL stream_data got=%h exp=%h", dd, ex); end end
            end
            checks++; if (dut_occ !== 2'd1) begin failures++; $display("FAIL stream_occ k=%0d got=%0d exp=1", k, dut_occ); end
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, upf, dnf, dd, ur, dv);
        checks++;
        if (!dnf || sb.size() == 0) begin failures++; $display("FAIL stream_last dn_valid=%b exp=1", dv); end
        else begin ex = sb.pop_front(); if (dd !== ex) begin failures++; $display("FAIL stream_last got=%h exp=%h", dd, ex); end end
        checks++; if (dut_occ !== 2'd0) begin failures++; $display("FAIL stream_empty got=%0d exp=0", dut_occ); end
    endtask

    task automatic test_skid();
        bit upf, dnf; logic [31:0] dd, ex; logic ur, dv;
        cyc(1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 1'b0, upf, dnf, dd, ur, dv);
        cyc(1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 1'b0, upf, dnf, dd, ur, dv);
        checks++; if (dut_occ !== 2'(sb.size()) || dut_occ !== 2'd2) begin failures++; $display("FAIL skid_occ got=%0d exp=2", dut_occ); end
        checks++; if (dut_up_ready !== 1'b0) begin failures++; $display("FAIL skid_up_ready got=%b exp=0", dut_up_ready); end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, upf, dnf, dd, ur, dv);
            checks++;
            if (!dnf || sb.size() == 0) begin failures++; $display("FAIL skid_drain i=%0d dn_valid=%b exp=1", i, dv); end
            else begin ex = sb.pop_front(); if (dd !== ex) begin failures++; $display("FAIL skid_order got=%h exp=%h", dd, ex); end end
            checks++; if (dut_up_ready !== 1'b1) begin failures++; $display("FAIL skid_ready_back got=%b exp=1", dut_up_ready); end
        end
        checks++; if (dut_occ !== 2'd0) begin failures++; $display("FAIL skid_empty got=%0d exp=0", dut_occ); end
    endtask

    task automatic test_flush();
        bit upf, dnf; logic [31:0] dd; logic ur, dv; int st;
        cyc(1'b1, 32'h1, 1'b0, 1'b0, 1'b1, 1'b0, upf, dnf, dd, ur, dv);
        cyc(1'b1, 32'h2, 1'b0, 1'b0, 1'b1, 1'b0, upf, dnf, dd, ur, dv);
        st = exp_stall;
        cyc(1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 1'b0, upf, dnf, dd, ur, dv);
        checks++; if (dut_dn_valid !== 1'b0 || dut_occ !== 2'd0) begin
            failures++; $display("FAIL flush_kill got v=%b occ=%0d exp 0/0", dut_dn_valid, dut_occ);
        end
        checks++; if (dut_stall !== 16'(st)) begin failures++; $display("FAIL flush_stall got=%0d exp=%0d", dut_stall, st); end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, upf, dnf, dd, ur, dv);
            checks++; if (dv !== 1'b0) begin failures++; $display("FAIL flush_leak got dn_valid=%b data=%h exp=0", dv, dd); end
        end
    endtask

    task automatic test_pause();
        bit upf, dnf; logic [31:0] dd, ex; logic ur, dv;
        cyc(1'b1, 32'h5, 1'b0, 1'b0, 1'b1, 1'b0, upf, dnf, dd, ur, dv);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 32'h77, 1'b1, 1'b1, 1'b0, 1'b0, upf, dnf, dd, ur, dv);
            checks++;
            if (dut_occ !== 2'd1 || dut_dn_valid !== 1'b1 || dut_dn_data !== 32'h5 || dut_stall !== 16'(exp_stall)) begin
                failures++;
                $display("FAIL pause_hold got occ=%0d v=%b d=%h stall=%0d exp 1/1/5/%0d",
                         dut_occ, dut_dn_valid, dut_dn_data, dut_stall, exp_stall);
            end
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, upf, dnf, dd, ur, dv);
        checks++;
        if (!dnf || sb.size() == 0) begin failures++; $display("FAIL pause_resume dn_valid=%b exp=1", dv); end
        else begin ex = sb.pop_front(); if (dd !== ex) begin failures++; $display("FAIL pause_data got=%h exp=%h", dd, ex); end end
        checks++; if (dut_occ !== 2'd0) begin failures++; $display("FAIL pause_empty got=%0d exp=0", dut_occ); end
    endtask

    task automatic test_saturation();
        bit upf, dnf; logic [31:0] dd; logic ur, dv; int ex;
        do_reset();
        cyc(1'b1, 32'h9, 1'b0, 1'b0, 1'b1, 1'b0, upf, dnf, dd, ur, dv);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, upf, dnf, dd, ur, dv);
            ex = (i + 1 > 7) ? 7 : i + 1;
            checks++; if (sat_stall !== 3'(ex)) begin failures++; $display("FAIL sat_cnt i=%0d got=%0d exp=%0d", i, sat_stall, ex); end
        end
        checks++; if (dut_stall !== 16'd10) begin failures++; $display("FAIL wide_cnt got=%0d exp=10", dut_stall); end
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, upf, dnf, dd, ur, dv);
        checks++; if (sat_stall !== 3'd7 || sat_dn_valid !== 1'b0) begin
            failures++; $display("FAIL sat_flush got cnt=%0d v=%b exp 7/0", sat_stall, sat_dn_valid);
        end
    endtask

    task automatic test_noskid();
        bit upf, dnf; logic [31:0] dd, ex; logic ur, dv, v, dr, fl;
        do_reset();
        for (int i = 0; i < 320; i++) begin
            v  = (i < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
            dr = (i < 300) ? 1'($urandom_range(0, 1)) : 1'b1;
            fl = (i < 300) && ($urandom_range(0, 15) == 0);
            cyc(v, $urandom, dr, fl, 1'b1, 1'b1, upf, dnf, dd, ur, dv);
            checks++; if (ur !== (~dv | dr)) begin failures++; $display("FAIL ns_ready i=%0d got=%b exp=%b", i, ur, ~dv | dr); end
            if (dnf) begin
                checks++;
                if (sb.size() == 0) begin failures++; $display("FAIL ns_extra i=%0d data=%h exp none", i, dd); end
                else begin ex = sb.pop_front(); if (dd !== ex) begin failures++; $display("FAIL ns_order i=%0d got=%h exp=%h", i, dd, ex); end end
            end
            checks++; if (ns_occ > 2'd1 || ns_occ !== 2'(sb.size())) begin
                failures++; $display("FAIL ns_occ i=%0d got=%0d exp=%0d", i, ns_occ, sb.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_pause();
        test_saturation();
        test_noskid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
